// File: rtl/byte_reg_write_arbiter_pkg.sv
// Shared definitions for the byte register write arbiter.
// State encoding and the default requester count.
package byte_reg_write_arbiter_pkg;

  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/byte_reg_write_arbiter_rr_select.sv
// Combinational round-robin picker.
// Returns the first requester at or after prio_ptr, wrapping.
module rr_select #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] prio_ptr,
  output logic [PTR_W-1:0] sel,
  output logic             any_req
);

  logic [PTR_W-1:0] idx;

  // scan upward from prio_ptr; pointer width makes the wrap free
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = prio_ptr + PTR_W'(k);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

endmodule

// File: rtl/byte_register.sv
// Shared 8-bit data-bus latch used by all pipeline stages.
// Clears asynchronously on res, loads d when en is high.
module byte_register (
  input  logic       clk,
  input  logic       res,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  // storage: async clear, enabled load
  always_ff @(posedge clk or posedge res) begin
    if (res) q <= 8'h00;
    else if (en) q <= d;
  end

endmodule

// File: rtl/byte_reg_write_arbiter.sv
// Round-robin write arbiter for the shared byte register.
// IDLE -> GRANT -> ACK handshake, one write per three cycles.
module byte_reg_write_arbiter
  import byte_reg_write_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        q,
  output logic [PTR_W-1:0]  owner,
  output logic              busy,
  output logic [7:0]        wr_count
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] prio_q, prio_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [PTR_W-1:0] sel;
  logic             any_req;
  logic             en;
  logic [7:0]       d;

  rr_select #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_sel (
    .req      (req),
    .prio_ptr (prio_q),
    .sel      (sel),
    .any_req  (any_req)
  );

  // write only while the owner still holds its request
  assign en = (state_q == ST_GRANT) && req[owner_q] && !res;
  assign d  = wdata[{owner_q, 3'b000} +: 8];

  byte_register u_reg (
    .clk (clk),
    .res (res),
    .en  (en),
    .d   (d),
    .q   (q)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    ack_d   = '0;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_GRANT;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
        end
      end
      ST_GRANT: begin
        if (req[owner_q]) begin
          state_d        = ST_ACK;
          ack_d[owner_q] = 1'b1;
          cnt_d          = cnt_q + 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        prio_d  = owner_q + PTR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign owner    = owner_q;
  assign busy     = (state_q != ST_IDLE);
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_byte_reg_write_arbiter.sv
// Scoreboard bench for byte_reg_write_arbiter.
// Stimulus pushes expected acks; a negedge monitor checks them.
module tb_byte_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  wr_count;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] q;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] gq[$];
  logic [7:0] exp_cnt;
  int         passed = 0;
  int         total  = 0;

  byte_reg_write_arbiter dut (
    .clk      (clk),
    .res      (res),
    .req      (req),
    .wdata    (wdata),
    .grant    (grant),
    .ack      (ack),
    .q        (q),
    .owner    (owner),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endfunction

  // monitor: every ack pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!res && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("ack_q", 32'(q), 32'(e.q));
        chk("ack_wr_count", 32'(wr_count), 32'(e.cnt));
      end
    end
  end

  task automatic expect_wr(input int i, input logic [7:0] v);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.ack = 4'b0001 << i;
    e.q   = v;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r);
    @(posedge clk);
    #1;
    req = r;
  endtask

  // requesters drop req on their ack; returns edges until idle
  task automatic run_idle(output int edges);
    int n = 0;
    gq.delete();
    do begin
      @(negedge clk);
      n++;
      if (grant != 4'b0000) gq.push_back(grant);
      req = req & ~ack;
    end while ((req != 4'b0000 || busy) && n < 200);
    if (n >= 200) chk("run_timeout", 32'(n), 32'd0);
    edges = n - 1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    req = '0;
    exp_cnt = '0;
    #20;
    @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    logic [7:0] v;
    res = 1'b1;
    req = '0;
    wdata = '0;
    exp_cnt = '0;
    #50;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    #50;
    res = 1'b0;

    // single request latency
    wdata[7:0] = 8'h0F;
    expect_wr(0, 8'h0F);
    drive(4'b0001);
    @(negedge clk);
    @(negedge clk);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_q_before", 32'(q), 32'h0);
    @(negedge clk);
    chk("t1_grant_drop", 32'(grant), 32'h0);
    chk("t1_q", 32'(q), 32'h0F);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_ack_once", 32'(ack), 32'h0);
    chk("t1_wr_count", 32'(wr_count), 32'h1);

    // contention from prio 0
    do_reset();
    wdata = 32'hDDCCBBAA;
    expect_wr(0, 8'hAA);
    expect_wr(1, 8'hBB);
    expect_wr(2, 8'hCC);
    expect_wr(3, 8'hDD);
    drive(4'b1111);
    run_idle(e);
    chk("cont_edges", 32'(e), 32'd12);
    chk("cont_ngrants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("cont_order", 32'(gq[i]), 32'(4'b0001 << i));
    chk("cont_q", 32'(q), 32'hDD);
    chk("cont_wr_count", 32'(wr_count), 32'd4);

    // fairness: win by 1 moves prio to 2, then 0 beats 1
    wdata[15:8] = 8'h11;
    expect_wr(1, 8'h11);
    drive(4'b0010);
    run_idle(e);
    wdata[7:0]  = 8'h01;
    wdata[15:8] = 8'h12;
    expect_wr(0, 8'h01);
    expect_wr(1, 8'h12);
    drive(4'b0011);
    run_idle(e);
    chk("fair_ngrants", 32'(gq.size()), 32'd2);
    if (gq.size() > 0) chk("fair_first", 32'(gq[0]), 32'h1);

    // abort: prio becomes 1 after this write
    wdata[7:0] = 8'h55;
    expect_wr(0, 8'h55);
    drive(4'b0001);
    run_idle(e);
    wdata[23:16] = 8'h77;
    drive(4'b0100);
    @(negedge clk);
    @(negedge clk);
    chk("abort_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'h0);
    chk("abort_no_grant", 32'(grant), 32'h0);
    chk("abort_q", 32'(q), 32'h55);
    chk("abort_wr_count", 32'(wr_count), 32'(exp_cnt));
    wdata[23:16] = 8'h22;
    wdata[31:24] = 8'h33;
    expect_wr(2, 8'h22);
    expect_wr(3, 8'h33);
    drive(4'b1100);
    run_idle(e);
    if (gq.size() > 0) chk("abort_prio_kept", 32'(gq[0]), 32'h4);

    // reset mid-GRANT
    wdata[15:8] = 8'hFF;
    drive(4'b0010);
    @(negedge clk);
    @(negedge clk);
    chk("mid_grant", 32'(grant), 32'h2);
    #2;
    res = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req = 4'b0000;
    res = 1'b0;
    exp_cnt = '0;
    repeat (3) @(negedge clk);
    chk("post_rst_q", 32'(q), 32'h0);
    chk("post_rst_wr_count", 32'(wr_count), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // counter wrap over 256 writes
    v = '0;
    for (int k = 0; k < 256; k++) begin
      v = 8'(k) ^ 8'hA5;
      wdata[8*(k%4) +: 8] = v;
      expect_wr(k % 4, v);
      drive(4'b0001 << (k % 4));
      run_idle(e);
    end
    chk("wrap_wr_count", 32'(wr_count), 32'h0);
    chk("wrap_q", 32'(q), 32'h5A);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/byte_reg_write_arbiter.md
Name: byte_reg_write_arbiter

Overview:
- Shares one 8-bit byte_register (the processor's shared data-bus latch) between NREQ write requesters.
- Requesters are the fetch, decode and execute stages plus the debug port.
- Round-robin arbitration, with a req/grant/ack handshake per transfer.
- The block owns the register's d/en/res pins and exposes q to every stage.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- PTR_W, 2, log2(NREQ); width of the owner and priority pointer.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- res  in  1  reset, asynchronous, active-high; also drives the byte_register res pin.
- req  in  NREQ  per-requester write request, level-sensitive.
- wdata  in  8*NREQ  write data; requester i uses slice [8*i+7:8*i].
- grant  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-cycle write-done pulse, registered.
- q  out  8  shared register contents, taken directly from byte_register q.
- owner  out  PTR_W  index of the current or last granted requester.
- busy  out  1  high when state is not IDLE.
- wr_count  out  8  count of completed writes; wraps 255 to 0.

Behaviour:
- Reset (res=1, asynchronous):
  - state=IDLE, grant=0, ack=0, owner=0, prio_ptr=0, wr_count=0, busy=0.
  - q=8'h00 via the byte_register reset.
  - The internal en is held 0 while res=1.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req is nonzero, select the first set bit scanning from prio_ptr upward, modulo NREQ.
  - At the next edge: state=GRANT, grant=onehot(sel), owner=sel.
  - If req is zero, stay in IDLE.
- GRANT:
  - Combinationally, en = req[owner] and d = wdata slice of owner.
  - If req[owner]=1 at the edge: the register captures d, state=ACK, ack[owner]=1, grant=0, wr_count+1.
  - If req[owner]=0 at the edge (abort): no write, state=IDLE, grant=0, no ack, prio_ptr unchanged.
- ACK:
  - ack is high for exactly this one cycle.
  - At the edge: state=IDLE, ack=0, prio_ptr=owner+1 mod NREQ.
- Latency: req rising before edge N gives grant after edge N, q updated and ack high after edge N+1, IDLE after edge N+2.
- Throughput: at most one write per 3 cycles.
- Requester obligations:
  - Hold wdata stable and req high while its grant is high.
  - Drop req in the ACK cycle; a req still high in IDLE is treated as a new request.
- Only one grant bit and at most one ack bit are ever high.
- Requests arriving during GRANT or ACK wait; they are arbitrated in the next IDLE cycle.
- Simultaneous requests: the winner is the lowest index at or after prio_ptr.
- The last winner gets lowest priority next round, so no requester starves.
- q holds its value whenever en=0, including in IDLE, ACK and the abort path.
- Reset mid-GRANT: the write is suppressed, q=0, and all outputs go to their reset values immediately.
- wr_count counts completed writes only; aborts are not counted.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_ACK=2'd2 (2'd3 is illegal and maps to IDLE);
  - the default NREQ.
- One sub-module, rr_select: combinational round-robin picker.
  - Inputs: req, prio_ptr.
  - Outputs: sel index, any_req.
- The existing byte_register is instantiated unchanged as the storage element.

Test Plan:
- Reset then single request:
  - Stimulus: res=1 for 100 ns, then res=0; req=4'b0001, wdata[7:0]=8'h0F.
  - Required: grant=0001 one cycle later; q=8'h0F and ack=0001 for one cycle after the next edge; wr_count=1.
- Contention:
  - Stimulus: req=4'b1111 held high, each requester dropping req on its ack; wdata slices AA, BB, CC, DD.
  - Required: grants in order 0,1,2,3; q takes AA, BB, CC, DD in turn; wr_count=4; exactly 12 cycles in total.
- Fairness:
  - Stimulus: prio_ptr=2 after a win by requester 1; req=4'b0011.
  - Required: requester 0 wins (wrap-around), not requester 1.
- Abort:
  - Stimulus: req[2] dropped during its GRANT cycle, with q=8'h55 beforehand.
  - Required: q stays 8'h55; no ack; wr_count unchanged; next arbitration still starts at the old prio_ptr.
- Reset mid-operation:
  - Stimulus: assert res asynchronously mid-GRANT with wdata=8'hFF.
  - Required: grant, ack and q are 0 immediately; no write once res releases; state=IDLE.
- Counter wrap:
  - Stimulus: 256 completed writes.
  - Required: wr_count returns to 8'h00; q holds the last written value.
